// File: rtl/dsram_arbiter_if.sv
// Request/response bundle for the two SRAM masters: instruction fetch (i_*) and memory stage (d_*).
// The master modport is the requester side; the slave modport is the arbiter side.
interface dsram_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [3:0]        d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [31:0]       d_rdata;

  modport master (
    output i_req, i_addr,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_wstrb, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata
  );

  modport slave (
    input  i_req, i_addr,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_wstrb, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata
  );
endinterface

// File: rtl/dsram_arbiter.sv
// Shares one single-port 1-cycle-latency SRAM between fetch (I) and memory stage (D).
// D has fixed priority; a starvation counter forces an I grant after STARVE_LIMIT D grants.
module dsram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  dsram_arbiter_if.slave    bus,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          r_resp_v;
  logic          r_resp_src;
  logic          w_force_i;
  logic          w_grant_d;
  logic          w_grant_i;

  always_comb begin
    w_force_i = bus.i_req & bus.d_req & (r_starve_cnt == CW'(STARVE_LIMIT));
    w_grant_d = ~reset & bus.d_req & ~w_force_i;
    w_grant_i = ~reset & bus.i_req & ~w_grant_d;
  end

  assign bus.d_addr_ok = w_grant_d;
  assign bus.i_addr_ok = w_grant_i;

  assign sram_en    = w_grant_d | w_grant_i;
  assign sram_we    = (w_grant_d & bus.d_wr) ? bus.d_wstrb : 4'b0000;
  assign sram_addr  = w_grant_d ? bus.d_addr : bus.i_addr;
  assign sram_wdata = w_grant_d ? bus.d_wdata : 32'h0;

  // Counts D grants that bypassed a waiting I; any other cycle clears it.
  always_ff @(posedge clk) begin
    if (reset)
      r_starve_cnt <= '0;
    else if (w_grant_d & bus.i_req) begin
      if (r_starve_cnt != CW'(STARVE_LIMIT))
        r_starve_cnt <= r_starve_cnt + CW'(1);
    end else
      r_starve_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_v   <= 1'b0;
      r_resp_src <= 1'b0;
    end else begin
      r_resp_v   <= w_grant_d | w_grant_i;
      r_resp_src <= w_grant_d;
    end
  end

  // Gated by reset so a response registered just before reset never surfaces.
  assign bus.d_data_ok = ~reset & r_resp_v & r_resp_src;
  assign bus.i_data_ok = ~reset & r_resp_v & ~r_resp_src;
  assign bus.d_rdata   = sram_rdata;
  assign bus.i_rdata   = sram_rdata;
endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed bench for dsram_arbiter with a behavioural 1-cycle SRAM model.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_dsram_arbiter;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic [31:0]       mem [0:255];

  int n_cmp;
  int n_err;

  dsram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dsram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      sram_rdata <= mem[sram_addr[9:2]];
    end
  end

  task automatic idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_wstrb = 4'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok, sram_en, sram_we} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got ok=%b%b%b%b en=%b we=%b, want all 0",
               bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok, sram_en, sram_we);
    end
    @(negedge clk);
    idle();
    reset = 1'b0;
  endtask

  task automatic test_i_only();
    logic [31:0] exp_rd [0:2];
    exp_rd[0] = 32'hC0DE0040; exp_rd[1] = 32'hC0DE0041; exp_rd[2] = 32'hC0DE0042;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin
        bus.i_req = 1'b1; bus.i_addr = 32'h100 + 32'(k * 4);
      end else idle();
      #1;
      n_cmp++;
      if (bus.i_addr_ok !== (k < 3)) begin
        n_err++; $display("FAIL i_only_addr_ok[%0d]: got %b want %b", k, bus.i_addr_ok, k < 3);
      end
      n_cmp++;
      if (bus.i_data_ok !== (k > 0) || bus.d_data_ok !== 1'b0) begin
        n_err++; $display("FAIL i_only_data_ok[%0d]: got i=%b d=%b want i=%b d=0", k, bus.i_data_ok, bus.d_data_ok, k > 0);
      end
      if (k > 0) begin
        n_cmp++;
        if (bus.i_rdata !== exp_rd[k-1]) begin
          n_err++; $display("FAIL i_only_rdata[%0d]: got %h want %h", k, bus.i_rdata, exp_rd[k-1]);
        end
      end
    end
  endtask

  task automatic test_d_write_read();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_wstrb = 4'b0011;
    bus.d_addr = 32'h20; bus.d_wdata = 32'hAABBCCDD;
    #1;
    n_cmp++;
    if (bus.d_addr_ok !== 1'b1 || sram_we !== 4'b0011 || sram_wdata !== 32'hAABBCCDD || sram_addr !== 32'h20) begin
      n_err++; $display("FAIL dwr_grant: got ok=%b we=%b wd=%h a=%h want 1 0011 aabbccdd 20",
                        bus.d_addr_ok, sram_we, sram_wdata, sram_addr);
    end
    @(negedge clk);
    bus.d_wr = 1'b0; bus.d_wstrb = 4'b0; bus.d_wdata = '0;
    #1;
    n_cmp++;
    if (bus.d_addr_ok !== 1'b1 || bus.d_data_ok !== 1'b1 || sram_we !== 4'b0) begin
      n_err++; $display("FAIL drd_grant: got ok=%b data_ok=%b we=%b want 1 1 0000", bus.d_addr_ok, bus.d_data_ok, sram_we);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (bus.d_data_ok !== 1'b1 || bus.d_rdata !== 32'h1122CCDD) begin
      n_err++; $display("FAIL drd_data: got ok=%b rdata=%h want 1 1122ccdd", bus.d_data_ok, bus.d_rdata);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_addr = 32'h24; bus.i_req = 1'b1; bus.i_addr = 32'h104;
    #1;
    n_cmp++;
    if (bus.d_addr_ok !== 1'b1 || bus.i_addr_ok !== 1'b0) begin
      n_err++; $display("FAIL sim_first: got d=%b i=%b want d=1 i=0", bus.d_addr_ok, bus.i_addr_ok);
    end
    @(negedge clk);
    bus.d_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.i_addr_ok !== 1'b1 || bus.d_data_ok !== 1'b1 || bus.d_rdata !== 32'hC0DE0009) begin
      n_err++; $display("FAIL sim_second: got i_ok=%b d_data_ok=%b rdata=%h want 1 1 c0de0009",
                        bus.i_addr_ok, bus.d_data_ok, bus.d_rdata);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (bus.i_data_ok !== 1'b1 || bus.d_data_ok !== 1'b0 || bus.i_rdata !== 32'hC0DE0041) begin
      n_err++; $display("FAIL sim_third: got i=%b d=%b rdata=%h want 1 0 c0de0041",
                        bus.i_data_ok, bus.d_data_ok, bus.i_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_d;
    logic prev_d;
    prev_d = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 10) begin
        bus.d_req = 1'b1; bus.d_addr = 32'h30; bus.i_req = 1'b1; bus.i_addr = 32'h108;
      end else idle();
      #1;
      if (k < 10) begin
        exp_d = (k % 5) != 4;
        n_cmp++;
        if (bus.d_addr_ok !== exp_d || bus.i_addr_ok !== !exp_d) begin
          n_err++; $display("FAIL starve_grant[%0d]: got d=%b i=%b want d=%b i=%b",
                            k, bus.d_addr_ok, bus.i_addr_ok, exp_d, !exp_d);
        end
      end else exp_d = 1'b0;
      if (k > 0) begin
        n_cmp++;
        if (bus.d_data_ok !== prev_d || bus.i_data_ok !== !prev_d) begin
          n_err++; $display("FAIL starve_resp[%0d]: got d=%b i=%b want d=%b i=%b",
                            k, bus.d_data_ok, bus.i_data_ok, prev_d, !prev_d);
        end
      end
      prev_d = exp_d;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_addr = 32'h20;
    #1;
    n_cmp++;
    if (bus.d_addr_ok !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_grant: got %b want 1", bus.d_addr_ok);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.d_wr = 1'b1; bus.d_wstrb = 4'hF; bus.i_req = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok, sram_en, sram_we} !== 9'b0) begin
      n_err++; $display("FAIL rst_mid_outputs: got ok=%b%b%b%b en=%b we=%b want all 0",
                        bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok, sram_en, sram_we);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (bus.d_data_ok !== 1'b0 || bus.i_data_ok !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_dropped: got d=%b i=%b want 0 0", bus.d_data_ok, bus.i_data_ok);
    end
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_addr = 32'h24;
    #1;
    n_cmp++;
    if (bus.d_addr_ok !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_resume: got %b want 1", bus.d_addr_ok);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (bus.d_data_ok !== 1'b1 || bus.d_rdata !== 32'hC0DE0009) begin
      n_err++; $display("FAIL rst_mid_data: got ok=%b rdata=%h want 1 c0de0009", bus.d_data_ok, bus.d_rdata);
    end
  endtask

  task automatic test_zero_strobe();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_wstrb = 4'b0;
    bus.d_addr = 32'h28; bus.d_wdata = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if (bus.d_addr_ok !== 1'b1 || sram_en !== 1'b1 || sram_we !== 4'b0) begin
      n_err++; $display("FAIL zstrb_grant: got ok=%b en=%b we=%b want 1 1 0000", bus.d_addr_ok, sram_en, sram_we);
    end
    @(negedge clk);
    bus.d_wr = 1'b0; bus.d_wdata = '0;
    #1;
    n_cmp++;
    if (bus.d_data_ok !== 1'b1) begin
      n_err++; $display("FAIL zstrb_data_ok: got %b want 1", bus.d_data_ok);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (bus.d_rdata !== 32'hC0DE000A) begin
      n_err++; $display("FAIL zstrb_unchanged: got %h want c0de000a", bus.d_rdata);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int w = 0; w < 256; w++) mem[w] = {16'hC0DE, 16'(w)};
    mem[8] = 32'h11223344;
    test_reset();
    test_i_only();
    test_d_write_read();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_zero_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
